tristate_bus_reader: RTL and testbench

//  Read-side master for a shared tri-state data bus fed by NrOfSources register sources with active-low chip select.

---
 rtl/tristate_bus_reader_pkg.sv | 12 +
 rtl/tristate_bus_reader_if.sv | 29 ++
 rtl/tristate_bus_reader_sel_decoder.sv | 23 ++
 rtl/tristate_bus_reader.sv | 116 +++++++++++
 tb/tb_tristate_bus_reader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tristate_bus_reader_pkg.sv
// Shared state encoding and counter sizing for the tri-state bus read master.
package tristate_bus_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SELECT  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam int unsigned CNT_BITS = 4;

endpackage

// File: rtl/tristate_bus_reader_if.sv
// Request, chip-select/bus and response signals of the tri-state bus reader.
interface tristate_bus_reader_if #(
  parameter int unsigned NrOfBits    = 32,
  parameter int unsigned NrOfSources = 4,
  parameter int unsigned SelBits     = 2
);
  import tristate_bus_reader_pkg::*;

  logic                   ReqValid;
  logic [SelBits-1:0]     ReqSel;
  logic                   ReqReady;
  logic [NrOfSources-1:0] cs_n;
  logic [NrOfBits-1:0]    Bus;
  logic                   RspValid;
  logic [NrOfBits-1:0]    RspData;
  logic                   RspError;
  logic                   RspReady;

  modport master (
    input  ReqValid, ReqSel, Bus, RspReady,
    output ReqReady, cs_n, RspValid, RspData, RspError
  );

  modport slave (
    output ReqValid, ReqSel, Bus, RspReady,
    input  ReqReady, cs_n, RspValid, RspData, RspError
  );

endinterface

// File: rtl/tristate_bus_reader_sel_decoder.sv
// Source index + enable to active-low one-hot chip selects; all high when
// disabled or when the index names no existing source.
module tristate_sel_decoder
  import tristate_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfSources = 4,
  parameter int unsigned SelBits     = 2
) (
  input  logic [SelBits-1:0]     sel,
  input  logic                   en,
  output logic [NrOfSources-1:0] cs_n
);

  always_comb begin
    cs_n = '1;
    if (en) begin
      for (int unsigned i = 0; i < NrOfSources; i++) begin
        if (32'(sel) == i) cs_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_reader.sv
// Read-side master for a shared tri-state bus: select one source, let it
// settle for SettleCycles Ticks, capture the bus and hand the word downstream.
module tristate_bus_reader
  import tristate_bus_reader_pkg::*;
#(
  parameter int unsigned NrOfBits     = 32,
  parameter int unsigned NrOfSources  = 4,
  parameter int unsigned SelBits      = 2,
  parameter int unsigned SettleCycles = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  tristate_bus_reader_if.master rd
);

  localparam logic [CNT_BITS-1:0] SETTLE_INIT = CNT_BITS'(SettleCycles);

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [NrOfSources-1:0] cs_n_q, cs_n_d;
  logic [NrOfSources-1:0] dec_cs_n;
  logic [NrOfBits-1:0]    data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   accept;
  logic                   in_range;

  assign accept   = (state_q == ST_IDLE) && rd.ReqValid && Tick;
  assign in_range = 32'(rd.ReqSel) < NrOfSources;

  tristate_sel_decoder #(
    .NrOfSources (NrOfSources),
    .SelBits     (SelBits)
  ) u_sel_decoder (
    .sel  (rd.ReqSel),
    .en   (accept && in_range),
    .cs_n (dec_cs_n)
  );

  // Break-before-make falls out of the state order: cs_n is released on the
  // capture edge and only RESPOND -> IDLE -> accept can select again (>=2 clocks).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_range) begin
            cs_n_d  = dec_cs_n;
            cnt_d   = SETTLE_INIT;
            state_d = ST_SELECT;
          end else begin
            err_d   = 1'b1;
            data_d  = '0;
            valid_d = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_SELECT: begin
        if (Tick) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_BITS'(1);
          end else begin
            data_d  = rd.Bus;
            err_d   = 1'b0;
            valid_d = 1'b1;
            cs_n_d  = '1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        if (rd.RspReady) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cs_n_d  = '1;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cs_n_q  <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign rd.ReqReady = (state_q == ST_IDLE);
  assign rd.cs_n     = cs_n_q;
  assign rd.RspValid = valid_q;
  assign rd.RspData  = data_q;
  assign rd.RspError = err_q;

endmodule

// File: tb/tb_tristate_bus_reader.sv
// Directed bench for tristate_bus_reader with a response scoreboard and
// chip-select invariant monitors; two instances cover both settle settings.
module tb_tristate_bus_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic Clock = 1'b0;
  logic Reset;
  logic Tick_a;
  logic Tick_b = 1'b0;
  int   tick_ph = 0;
  int   total = 0;
  int   bad = 0;
  rsp_t q_a[$];
  rsp_t q_b[$];
  int   gap_a = 0;
  bit   seen_a = 1'b0;

  always #5 Clock = ~Clock;

  tristate_bus_reader_if #(.NrOfBits(32), .NrOfSources(4), .SelBits(3)) ifc_a ();
  tristate_bus_reader_if #(.NrOfBits(32), .NrOfSources(4), .SelBits(2)) ifc_b ();

  tristate_bus_reader #(
    .NrOfBits(32), .NrOfSources(4), .SelBits(3), .SettleCycles(1)
  ) u_a (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick_a),
    .rd    (ifc_a)
  );

  tristate_bus_reader #(
    .NrOfBits(32), .NrOfSources(4), .SelBits(2), .SettleCycles(2)
  ) u_b (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Tick_b),
    .rd    (ifc_b)
  );

  function automatic logic [31:0] src_word(input int unsigned i);
    return 32'hA5A5_0001 + i;
  endfunction

  // Tri-state sources resolved as wired-OR; a conflict would corrupt the data.
  always_comb begin
    logic [31:0] acc_a;
    logic [31:0] acc_b;
    acc_a = '0;
    acc_b = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!ifc_a.cs_n[i]) acc_a = acc_a | src_word(i);
      if (!ifc_b.cs_n[i]) acc_b = acc_b | src_word(i);
    end
    ifc_a.Bus = acc_a;
    ifc_b.Bus = acc_b;
  end

  always begin
    @(posedge Clock);
    #2;
    tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
    Tick_b  = (tick_ph == 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; everything is sampled at the falling edge.
  task automatic next_drive();
    @(posedge Clock);
    #2;
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      gap_a  = 0;
      seen_a = 1'b0;
    end else begin
      check("onecold_a", 64'($countones(~ifc_a.cs_n) <= 1), 64'(1));
      check("onecold_b", 64'($countones(~ifc_b.cs_n) <= 1), 64'(1));
      if (ifc_a.cs_n == 4'hF) begin
        gap_a++;
      end else begin
        if (gap_a > 0 && seen_a) check("bbm_gap_a", 64'(gap_a >= 2), 64'(1));
        seen_a = 1'b1;
        gap_a  = 0;
      end
      if (ifc_a.RspValid && ifc_a.RspReady) begin
        check("rsp_pending_a", 64'(q_a.size() != 0), 64'(1));
        if (q_a.size() != 0) begin
          rsp_t e;
          e = q_a.pop_front();
          check("rsp_data_a", 64'(ifc_a.RspData), 64'(e.data));
          check("rsp_err_a", 64'(ifc_a.RspError), 64'(e.err));
        end
      end
      if (ifc_b.RspValid && ifc_b.RspReady) begin
        check("rsp_pending_b", 64'(q_b.size() != 0), 64'(1));
        if (q_b.size() != 0) begin
          rsp_t e;
          e = q_b.pop_front();
          check("rsp_data_b", 64'(ifc_b.RspData), 64'(e.data));
          check("rsp_err_b", 64'(ifc_b.RspError), 64'(e.err));
        end
      end
    end
  end

  task automatic read_a(input logic [2:0] sel, input logic [31:0] d, input logic e);
    int   n;
    rsp_t r;
    n      = 0;
    r.data = d;
    r.err  = e;
    q_a.push_back(r);
    ifc_a.ReqValid = 1'b1;
    ifc_a.ReqSel   = sel;
    @(negedge Clock);
    while (!(ifc_a.ReqReady && Tick_a) && n < 20) begin
      n++;
      @(negedge Clock);
    end
    check("accept_timeout_a", 64'(n < 20), 64'(1));
    next_drive();
    ifc_a.ReqValid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (q_a.size() != 0 && n < 40) begin
      n++;
      next_drive();
    end
    check("drain_timeout_a", 64'(q_a.size() == 0), 64'(1));
  endtask

  initial begin
    int low;
    int ticks;
    int n;
    rsp_t r;

    Reset          = 1'b1;
    Tick_a         = 1'b1;
    ifc_a.ReqValid = 1'b0;
    ifc_a.ReqSel   = '0;
    ifc_a.RspReady = 1'b0;
    ifc_b.ReqValid = 1'b0;
    ifc_b.ReqSel   = '0;
    ifc_b.RspReady = 1'b0;

    // Reset state
    @(negedge Clock);
    check("rst_cs_n", 64'(ifc_a.cs_n), 64'(4'hF));
    check("rst_valid", 64'(ifc_a.RspValid), 64'(0));
    check("rst_data", 64'(ifc_a.RspData), 64'(0));
    check("rst_ready", 64'(ifc_a.ReqReady), 64'(1));
    next_drive();
    Reset = 1'b0;

    // Basic read of source 2, then hold the response under backpressure
    next_drive();
    r.data = 32'hA5A5_0003;
    r.err  = 1'b0;
    q_a.push_back(r);
    ifc_a.ReqValid = 1'b1;
    ifc_a.ReqSel   = 3'd2;
    @(negedge Clock);
    check("t2_req_ready", 64'(ifc_a.ReqReady), 64'(1));
    next_drive();
    ifc_a.ReqValid = 1'b0;
    for (int unsigned i = 0; i < 2; i++) begin
      @(negedge Clock);
      check("t2_cs_low", 64'(ifc_a.cs_n), 64'(4'b1011));
      check("t2_not_valid", 64'(ifc_a.RspValid), 64'(0));
    end
    @(negedge Clock);
    check("t2_valid", 64'(ifc_a.RspValid), 64'(1));
    check("t2_data", 64'(ifc_a.RspData), 64'(32'hA5A5_0003));
    check("t2_err", 64'(ifc_a.RspError), 64'(0));
    check("t2_cs_released", 64'(ifc_a.cs_n), 64'(4'hF));
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge Clock);
      check("bp_valid", 64'(ifc_a.RspValid), 64'(1));
      check("bp_data", 64'(ifc_a.RspData), 64'(32'hA5A5_0003));
      check("bp_req_ready", 64'(ifc_a.ReqReady), 64'(0));
      check("bp_cs_n", 64'(ifc_a.cs_n), 64'(4'hF));
    end
    next_drive();
    ifc_a.RspReady = 1'b1;
    next_drive();
    @(negedge Clock);
    check("bp_idle_ready", 64'(ifc_a.ReqReady), 64'(1));
    check("bp_idle_valid", 64'(ifc_a.RspValid), 64'(0));
    check("bp_sb_empty", 64'(q_a.size()), 64'(0));

    // Back-to-back reads of sources 0 and 3
    next_drive();
    read_a(3'd0, 32'hA5A5_0001, 1'b0);
    read_a(3'd3, 32'hA5A5_0004, 1'b0);
    drain_a();

    // Out-of-range selects, then an in-range read clears the error flag
    ifc_a.RspReady = 1'b0;
    read_a(3'd5, 32'h0, 1'b1);
    @(negedge Clock);
    check("t6_valid", 64'(ifc_a.RspValid), 64'(1));
    check("t6_err", 64'(ifc_a.RspError), 64'(1));
    check("t6_data", 64'(ifc_a.RspData), 64'(0));
    check("t6_cs_n", 64'(ifc_a.cs_n), 64'(4'hF));
    next_drive();
    ifc_a.RspReady = 1'b1;
    drain_a();
    read_a(3'd4, 32'h0, 1'b1);
    drain_a();
    read_a(3'd1, 32'hA5A5_0002, 1'b0);
    drain_a();

    // Tick every third clock with two settle Ticks on the second instance
    next_drive();
    ifc_b.RspReady = 1'b1;
    ifc_b.ReqValid = 1'b1;
    ifc_b.ReqSel   = 2'd1;
    r.data = 32'hA5A5_0002;
    r.err  = 1'b0;
    q_b.push_back(r);
    n = 0;
    @(negedge Clock);
    while (!(ifc_b.ReqReady && Tick_b) && n < 20) begin
      n++;
      @(negedge Clock);
    end
    check("t4_accept_timeout", 64'(n < 20), 64'(1));
    next_drive();
    ifc_b.ReqValid = 1'b0;
    low   = 0;
    ticks = 0;
    n     = 0;
    @(negedge Clock);
    while (!ifc_b.RspValid && n < 30) begin
      if (ifc_b.cs_n == 4'b1101) begin
        low++;
        if (Tick_b) ticks++;
      end
      n++;
      @(negedge Clock);
    end
    check("t4_rsp_timeout", 64'(n < 30), 64'(1));
    check("t4_cs_low_clocks", 64'(low), 64'(9));
    check("t4_cs_low_ticks", 64'(ticks), 64'(3));
    next_drive();
    next_drive();
    check("t4_sb_empty", 64'(q_b.size()), 64'(0));

    // Reset while a source is selected: bus released at once, no response
    ifc_a.RspReady = 1'b0;
    ifc_a.ReqValid = 1'b1;
    ifc_a.ReqSel   = 3'd2;
    @(negedge Clock);
    check("rs_ready", 64'(ifc_a.ReqReady), 64'(1));
    next_drive();
    ifc_a.ReqValid = 1'b0;
    @(negedge Clock);
    check("rs_selected", 64'(ifc_a.cs_n), 64'(4'b1011));
    #1;
    Reset = 1'b1;
    #1;
    check("rs_cs_n", 64'(ifc_a.cs_n), 64'(4'hF));
    check("rs_valid", 64'(ifc_a.RspValid), 64'(0));
    check("rs_data", 64'(ifc_a.RspData), 64'(0));
    check("rs_err", 64'(ifc_a.RspError), 64'(0));
    next_drive();
    Reset = 1'b0;
    ifc_a.RspReady = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge Clock);
      check("rs_no_rsp", 64'(ifc_a.RspValid), 64'(0));
      check("rs_bus_free", 64'(ifc_a.cs_n), 64'(4'hF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
